// File: rtl/kbd_fifo_port.sv
// Multi-source keyboard input port: round-robin arbiter feeding a FIFO that is
// read through the KBD/KBDCR register pair on the 6502 bus.
module kbd_fifo_port #(
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 16,
    parameter int LW       = $clog2(DEPTH) + 1
) (
    input  logic                  clk14,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  cs,
    input  logic                  address,
    input  logic                  we,
    input  logic [7:0]            din,
    output logic [7:0]            dout,
    input  logic [CHANNELS-1:0]   src_valid,
    input  logic [7*CHANNELS-1:0] src_data,
    input  logic [CHANNELS-1:0]   src_en,
    output logic [CHANNELS-1:0]   src_ready,
    output logic [LW-1:0]         level
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [6:0]    mem_q [DEPTH];
    logic [6:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          pop_pend_q, pop_pend_d;
    logic [CW-1:0] last_q, last_d;
    logic [7:0]    dout_q, dout_d;

    logic [CW-1:0] grant;
    logic          grant_vld;
    logic [CW:0]   cand;
    logic          full, empty, flush_now, kbd_rd, push, pop;
    logic [6:0]    push_data;

    // Search starts one past the last accepted channel so every enabled source gets a turn.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        cand      = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            cand = {1'b0, last_q} + (CW+1)'(k);
            if (cand >= (CW+1)'(CHANNELS)) begin
                cand = cand - (CW+1)'(CHANNELS);
            end
            if (!grant_vld && src_valid[cand[CW-1:0]] && src_en[cand[CW-1:0]]) begin
                grant_vld = 1'b1;
                grant     = cand[CW-1:0];
            end
        end
    end

    always_comb begin
        full      = (level_q == LW'(DEPTH));
        empty     = (level_q == '0);
        flush_now = enable & cs & we & address & din[0];
        kbd_rd    = enable & cs & ~we & ~address;
        // Ready is forced low in reset so no source sees an accept it cannot complete.
        push      = rst_n & grant_vld & ~full & ~flush_now;
        pop       = enable & pop_pend_q & ~empty & ~flush_now;
        push_data = src_data[7*int'(grant) +: 7];
        for (int i = 0; i < CHANNELS; i++) begin
            src_ready[i] = push && (grant == CW'(i));
        end
    end

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        pop_pend_d = pop_pend_q;
        last_d     = last_q;
        dout_d     = address ? {~empty, 7'b0} : {1'b1, mem_q[rd_ptr_q]};

        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            last_d          = grant;
        end

        if (flush_now) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            pop_pend_d = 1'b0;
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(push);
            rd_ptr_d = rd_ptr_q + AW'(pop);
            level_d  = level_q + LW'(push) - LW'(pop);
            // The pop is deferred one enable edge so the CPU samples the byte before it leaves.
            if (enable && pop_pend_q) begin
                pop_pend_d = 1'b0;
            end else if (kbd_rd && !empty) begin
                pop_pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk14 or negedge rst_n) begin
        if (!rst_n) begin
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            pop_pend_q <= 1'b0;
            last_q     <= CW'(CHANNELS - 1);
            dout_q     <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            pop_pend_q <= pop_pend_d;
            last_q     <= last_d;
            dout_q     <= dout_d;
        end
    end

    assign dout  = dout_q;
    assign level = level_q;

endmodule

// File: tb/tb_kbd_fifo_port.sv
// Directed bench for kbd_fifo_port: vector table for register/arbitration behaviour,
// hand-written sequences for full/wrap, flush races, push+pop and reset corner cases.
module tb_kbd_fifo_port;

    localparam int CH = 2;
    localparam int DP = 4;
    localparam int LW = $clog2(DP) + 1;

    logic          clk14 = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b1;
    logic          cs = 1'b0;
    logic          address = 1'b0;
    logic          we = 1'b0;
    logic [7:0]    din = '0;
    logic [7:0]    dout;
    logic [CH-1:0] src_valid = '0;
    logic [13:0]   src_data = '0;
    logic [CH-1:0] src_en = '1;
    logic [CH-1:0] src_ready;
    logic [LW-1:0] level;

    int n_checks = 0;
    int n_fail   = 0;

    kbd_fifo_port #(.CHANNELS(CH), .DEPTH(DP)) dut (
        .clk14(clk14), .rst_n(rst_n), .enable(enable), .cs(cs), .address(address),
        .we(we), .din(din), .dout(dout), .src_valid(src_valid), .src_data(src_data),
        .src_en(src_en), .src_ready(src_ready), .level(level)
    );

    always #5 clk14 = ~clk14;

    typedef struct {
        logic       pre_rst;
        logic       cs, adr, we;
        logic [7:0] din;
        logic [1:0] vld, en;
        logic [6:0] d0, d1;
        logic [1:0] e_rdy;
        logic [7:0] e_dout;
        logic [2:0] e_lvl;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic pr, input logic c, input logic a, input logic w,
                       input logic [7:0] di, input logic [1:0] v, input logic [1:0] e,
                       input logic [6:0] x0, input logic [6:0] x1, input logic [1:0] er,
                       input logic [7:0] ed, input logic [2:0] el);
        vec_t t;
        t.pre_rst = pr; t.cs = c; t.adr = a; t.we = w; t.din = di; t.vld = v; t.en = e;
        t.d0 = x0; t.d1 = x1; t.e_rdy = er; t.e_dout = ed; t.e_lvl = el;
        tbl.push_back(t);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk14);
        #1;
    endtask

    task automatic set_in(input logic c, input logic a, input logic w, input logic [7:0] di,
                          input logic [1:0] v, input logic [6:0] x0);
        cs = c; address = a; we = w; din = di; src_valid = v; src_data = {7'h00, x0};
    endtask

    task automatic push_byte(input logic [6:0] x);
        set_in(0, 1, 0, 8'h00, 2'b01, x);
        tick();
        set_in(0, 1, 0, 8'h00, 2'b00, 7'h00);
    endtask

    task automatic do_reset();
        set_in(0, 1, 0, 8'h00, 2'b11, 7'h2A);
        src_en = 2'b11;
        rst_n  = 1'b0;
        #1;
        chk("rst_ready", 8'(src_ready), 8'h00);
        chk("rst_level", 8'(level), 8'h00);
        chk("rst_dout", dout, 8'h00);
        tick();
        tick();
        chk("rst_hold_dout", dout, 8'h00);
        rst_n = 1'b1;
        set_in(0, 1, 0, 8'h00, 2'b00, 7'h00);
        #1;
    endtask

    initial begin
        // Basic register behaviour from reset.
        add(1, 1,1,0,8'h00, 2'b00,2'b11, 7'h00,7'h00, 2'b00, 8'h00, 3'd0);
        add(0, 1,0,0,8'h00, 2'b00,2'b11, 7'h00,7'h00, 2'b00, 8'h80, 3'd0);
        add(0, 0,1,0,8'h00, 2'b01,2'b11, 7'h41,7'h00, 2'b01, 8'h00, 3'd1);
        add(0, 0,1,0,8'h00, 2'b00,2'b11, 7'h00,7'h00, 2'b00, 8'h80, 3'd1);
        add(0, 1,0,0,8'h00, 2'b00,2'b11, 7'h00,7'h00, 2'b00, 8'hC1, 3'd1);
        add(0, 0,0,0,8'h00, 2'b00,2'b11, 7'h00,7'h00, 2'b00, 8'hC1, 3'd0);
        add(0, 0,1,0,8'h00, 2'b00,2'b11, 7'h00,7'h00, 2'b00, 8'h00, 3'd0);
        // Fairness: ch0 wins first after reset, then strict alternation until full.
        add(1, 0,1,0,8'h00, 2'b11,2'b11, 7'h31,7'h32, 2'b01, 8'h00, 3'd1);
        add(0, 0,1,0,8'h00, 2'b11,2'b11, 7'h31,7'h32, 2'b10, 8'h80, 3'd2);
        add(0, 0,1,0,8'h00, 2'b11,2'b11, 7'h31,7'h32, 2'b01, 8'h80, 3'd3);
        add(0, 0,1,0,8'h00, 2'b11,2'b11, 7'h31,7'h32, 2'b10, 8'h80, 3'd4);
        add(0, 0,1,0,8'h00, 2'b11,2'b11, 7'h31,7'h32, 2'b00, 8'h80, 3'd4);
        add(0, 1,0,0,8'h00, 2'b00,2'b11, 7'h00,7'h00, 2'b00, 8'hB1, 3'd4);
        add(0, 0,0,0,8'h00, 2'b00,2'b11, 7'h00,7'h00, 2'b00, 8'hB1, 3'd3);
        add(0, 1,0,0,8'h00, 2'b00,2'b11, 7'h00,7'h00, 2'b00, 8'hB2, 3'd3);
        add(0, 0,0,0,8'h00, 2'b00,2'b11, 7'h00,7'h00, 2'b00, 8'hB2, 3'd2);
        add(0, 1,0,0,8'h00, 2'b00,2'b11, 7'h00,7'h00, 2'b00, 8'hB1, 3'd2);
        add(0, 0,0,0,8'h00, 2'b00,2'b11, 7'h00,7'h00, 2'b00, 8'hB1, 3'd1);
        add(0, 1,0,0,8'h00, 2'b00,2'b11, 7'h00,7'h00, 2'b00, 8'hB2, 3'd1);
        add(0, 0,0,0,8'h00, 2'b00,2'b11, 7'h00,7'h00, 2'b00, 8'hB2, 3'd0);
        // ch1 disabled: only ch0 is ever granted.
        add(0, 0,1,0,8'h00, 2'b11,2'b01, 7'h31,7'h32, 2'b01, 8'h00, 3'd1);
        add(0, 0,1,0,8'h00, 2'b11,2'b01, 7'h31,7'h32, 2'b01, 8'h80, 3'd2);
        add(0, 0,1,0,8'h00, 2'b00,2'b01, 7'h00,7'h00, 2'b00, 8'h80, 3'd2);

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].pre_rst) do_reset();
            cs = tbl[i].cs; address = tbl[i].adr; we = tbl[i].we; din = tbl[i].din;
            src_valid = tbl[i].vld; src_en = tbl[i].en; src_data = {tbl[i].d1, tbl[i].d0};
            #1;
            chk($sformatf("v%0d_ready", i), 8'(src_ready), 8'(tbl[i].e_rdy));
            tick();
            chk($sformatf("v%0d_dout", i), dout, tbl[i].e_dout);
            chk($sformatf("v%0d_level", i), 8'(level), 8'(tbl[i].e_lvl));
        end

        // Full, blocked source, pop-then-accept and order across pointer wrap.
        do_reset();
        src_en = 2'b01;
        for (int i = 0; i < DP; i++) begin
            set_in(0, 1, 0, 8'h00, 2'b01, 7'(7'h50 + i));
            #1 chk("fill_ready", 8'(src_ready), 8'h01);
            tick();
        end
        chk("full_level", 8'(level), 8'd4);
        set_in(0, 1, 0, 8'h00, 2'b01, 7'h54);
        #1 chk("full_ready", 8'(src_ready), 8'h00);
        tick();
        chk("full_hold_level", 8'(level), 8'd4);
        set_in(1, 0, 0, 8'h00, 2'b01, 7'h54);
        tick();
        chk("full_read_dout", dout, 8'hD0);
        chk("full_read_level", 8'(level), 8'd4);
        set_in(0, 0, 0, 8'h00, 2'b01, 7'h54);
        #1 chk("full_pop_edge_ready", 8'(src_ready), 8'h00);
        tick();
        chk("full_pop_level", 8'(level), 8'd3);
        chk("held_ready", 8'(src_ready), 8'h01);
        tick();
        chk("held_accept_level", 8'(level), 8'd4);
        for (int i = 1; i <= DP; i++) begin
            set_in(1, 0, 0, 8'h00, 2'b00, 7'h00);
            tick();
            chk("wrap_order", dout, 8'(8'hD0 + i));
            set_in(0, 0, 0, 8'h00, 2'b00, 7'h00);
            tick();
        end
        chk("drain_level", 8'(level), 8'd0);

        // Flush racing a push: push refused, byte accepted afterwards.
        push_byte(7'h61); push_byte(7'h62); push_byte(7'h63);
        chk("pre_flush_level", 8'(level), 8'd3);
        set_in(1, 1, 1, 8'hA7, 2'b01, 7'h64);
        #1 chk("flush_ready", 8'(src_ready), 8'h00);
        tick();
        chk("flush_level", 8'(level), 8'd0);
        set_in(0, 1, 0, 8'h00, 2'b01, 7'h64);
        #1 chk("post_flush_ready", 8'(src_ready), 8'h01);
        tick();
        chk("post_flush_level", 8'(level), 8'd1);
        set_in(1, 0, 0, 8'h00, 2'b00, 7'h00);
        tick();
        chk("post_flush_dout", dout, 8'hE4);
        set_in(0, 0, 0, 8'h00, 2'b00, 7'h00);
        tick();
        chk("post_flush_pop", 8'(level), 8'd0);

        // KBDCR write with din[0]=0 is ignored; flush during pop_pend ends at 0.
        push_byte(7'h71);
        set_in(1, 1, 1, 8'hA6, 2'b00, 7'h00);
        tick();
        chk("noflush_level", 8'(level), 8'd1);
        set_in(1, 0, 0, 8'h00, 2'b00, 7'h00);
        tick();
        set_in(1, 1, 1, 8'h01, 2'b00, 7'h00);
        tick();
        chk("flush_pend_level", 8'(level), 8'd0);
        set_in(0, 1, 0, 8'h00, 2'b00, 7'h00);
        tick();
        chk("flush_pend_after", 8'(level), 8'd0);
        chk("flush_pend_dout", dout, 8'h00);

        // Push and pop on the same edge keep level; new byte lands last.
        push_byte(7'h72); push_byte(7'h73);
        tick();
        chk("pp_pre_level", 8'(level), 8'd2);
        set_in(1, 0, 0, 8'h00, 2'b00, 7'h00);
        tick();
        chk("pp_read_dout", dout, 8'hF2);
        set_in(0, 0, 0, 8'h00, 2'b01, 7'h74);
        #1 chk("pp_ready", 8'(src_ready), 8'h01);
        tick();
        chk("pp_level", 8'(level), 8'd2);
        for (int i = 3; i <= 4; i++) begin
            set_in(1, 0, 0, 8'h00, 2'b00, 7'h00);
            tick();
            chk("pp_order", dout, 8'(8'hF0 + i));
            set_in(0, 0, 0, 8'h00, 2'b00, 7'h00);
            tick();
        end
        chk("pp_drain", 8'(level), 8'd0);

        // Bus accesses only count on enable edges; the pop waits for the next one.
        push_byte(7'h75);
        enable = 1'b0;
        set_in(1, 0, 0, 8'h00, 2'b00, 7'h00);
        tick();
        enable = 1'b1;
        set_in(0, 0, 0, 8'h00, 2'b00, 7'h00);
        tick(); tick();
        chk("noen_read_level", 8'(level), 8'd1);
        set_in(1, 0, 0, 8'h00, 2'b00, 7'h00);
        tick();
        enable = 1'b0;
        set_in(0, 0, 0, 8'h00, 2'b00, 7'h00);
        tick(); tick();
        chk("pend_wait_level", 8'(level), 8'd1);
        enable = 1'b1;
        tick();
        chk("pend_apply_level", 8'(level), 8'd0);

        // Reset mid-operation discards contents and pending pop; ch0 wins again.
        push_byte(7'h76);
        set_in(1, 0, 0, 8'h00, 2'b00, 7'h00);
        tick();
        do_reset();
        tick();
        chk("midrst_level", 8'(level), 8'd0);
        set_in(0, 1, 0, 8'h00, 2'b11, 7'h31);
        src_data = {7'h32, 7'h31};
        #1 chk("midrst_grant", 8'(src_ready), 8'h01);
        tick();
        chk("midrst_push", 8'(level), 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/kbd_fifo_port.md
# kbd_fifo_port

Multi-source, FIFO-buffered replacement for the single-keyboard input port at 0xD010–0xD011. Arbitrates `CHANNELS` ASCII sources (PS/2 decoder, UART receiver, paste injector, …) round-robin into a `DEPTH`-entry FIFO. Presents KBD/KBDCR register semantics to the 6502 data bus, so typed or pasted text is never lost while the CPU is busy. Sits between the source adapters and the CPU data-in mux, clocked by `clk14` and qualified by `cpu_clken`.

## Interface
- `CHANNELS`, default 2: number of ASCII sources, 1..8.
- `DEPTH`, default 16: FIFO entries, power of two, ≥2.
- `LW`, derived as clog2(DEPTH)+1: width of `level`.
- `clk14`  in  1  master clock.
- `rst_n`  in  1  reset. Asynchronous assert, active-low. All state is cleared while low.
- `enable`  in  1  CPU clock enable (`cpu_clken`). Qualifies bus accesses.
- `cs`  in  1  chip select, asserted for 0xD010–0xD011.
- `address`  in  1  register select, taken from ab[0]. 0 = KBD, 1 = KBDCR.
- `we`  in  1  CPU write.
- `din`  in  8  CPU write data.
- `dout`  out  8  registered read data.
- `src_valid`  in  CHANNELS  per-source data valid. A source holds data until accepted.
- `src_data`  in  7*CHANNELS  per-source 7-bit ASCII. Channel i occupies bits [7i+6:7i].
- `src_en`  in  CHANNELS  per-source enable. A disabled source is never granted.
- `src_ready`  out  CHANNELS  per-source accept. A push occurs when valid & ready.
- `level`  out  LW  current FIFO occupancy, 0..DEPTH.

## Operation
- **Arbitration:** a `last` pointer records the most recently accepted channel and resets to CHANNELS-1, so channel 0 wins first. The grant goes to the first channel after `last`, in cyclic order, whose `src_valid` and `src_en` are both high. `last` updates only on an accepted push.
- **src_ready:** combinational. `src_ready[i]` = (i == grant) & ~full & ~flush_now. At most one bit is high per cycle. Pushes are evaluated on every `clk14` edge and are not gated by `enable`.
- **Storage:** the FIFO stores the 7-bit code. Write and read pointers are log2(DEPTH) bits and wrap modulo DEPTH. full = (level == DEPTH); empty = (level == 0).
- **KBD read (address 0, ~we):** returns {1'b1, head}. If the FIFO is empty, returns {1'b1, last head}, the stale entry, with no side effect.
- **KBD read pop:** a read on an `enable` edge with cs=1 while not empty sets `pop_pend`. On the next `enable` edge, the head advances, level decrements, and `pop_pend` clears. This matches the CPU's one-enable data sampling latency. A second KBD read while `pop_pend` is set does not queue a second pop.
- **KBDCR read (address 1):** returns {~empty, 7'b0}. No side effect.
- **KBDCR write:** if din[0]=1, flush. The flush executes on the `enable` edge of the write (flush_now). It clears both pointers, `level`, and `pop_pend`. Other bits are ignored. WozMon's init write of 0xA7 therefore flushes. Writes to address 0 are ignored.
- **Simultaneous push and pop:** both take effect, and `level` is unchanged. A push while full is blocked by `src_ready`, even if a pop applies on the same edge (no bypass). A push in the same cycle as a flush is refused.

## Timing
- **Reset values:** `dout`=0x00, `level`=0, `src_ready`=0 while `rst_n` is low, pointers 0, `pop_pend`=0, `last`=CHANNELS-1.
- **dout:** `dout` <= mux(address, state) on every `clk14` edge, a one-`clk14` latency identical to the RAM/ROM outputs. It is independent of `cs`.
- **Push latency:** a byte accepted on edge N appears in `level` and KBDCR bit7 after edge N. It is visible on `dout` at edge N+1, provided address=1 is held.
- **Pop timing:** the pop applies exactly one `enable` edge after the KBD access. `dout` holds the popped byte until then.
- **Reset mid-operation:** asserting `rst_n` discards the FIFO contents and any `pop_pend`. Sources must re-present their data after reset.

## Test plan
- **Reset and empty read:** hold rst_n low, release, then read KBDCR. Expect `dout`=0x00 and `level`=0. A KBD read does not change `level`.
- **Single push and pop:** ch0 pushes 0x41, then read KBDCR. Expect 0x80. Read KBD and expect 0xC1. After the next `enable` edge, `level`=0 and KBDCR reads 0x00.
- **Fairness:** ch0 and ch1 hold valid continuously with 0x31 and 0x32. Expect accepts to alternate 0x31, 0x32, 0x31, … starting with ch0. With src_en[1]=0, only 0x31 is accepted.
- **Full and wrap:** push DEPTH+1 bytes. Expect `level`=DEPTH, `src_ready`=0, and the last byte held by the source. Pop one; the held byte is accepted the cycle after. Read all entries; order is preserved across pointer wrap.
- **Flush races:** with `level`=3, write KBDCR 0xA7 in the same cycle as a ch0 valid. Expect `level`=0, the push refused, and the byte accepted on a later cycle. A flush during `pop_pend` leaves `level`=0, not −1.
- **Push and pop same cycle:** with `level`=2, hold ch0 valid on the edge where the pop applies. Expect `level` to remain 2 and the new byte to be last in order.
